execute_alu: RTL and testbench

Execute stage of the pipelined RV32I core. Consumes the operand pair and decoded control from the register-read stage. Produces:
- the write-back/forwarding triple (data, id, valid);
- the resolved branch target for conditional branches and JALR;
- the load/store request to the memory stage.

All outputs are registered. An optional multi-cycle serial shifter stalls upstream through `busy_o`.

---
 rtl/execute_alu.sv | 248 ++++++++++++++++++++++++
 tb/tb_execute_alu.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_alu.sv
// Execute stage of the pipelined RV32I core: ALU, branch resolution and load/store request
// generation, with registered outputs and an optional serial shifter that stalls upstream.
module execute_alu #(
    parameter int unsigned BARREL_SHIFTER = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  br_op,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  mem_size,
    input  logic [31:0] reg_op1,
    input  logic [31:0] reg_op2,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [5:0]  rd,
    output logic        busy_o,
    output logic [31:0] reg_data_o,
    output logic [5:0]  reg_id_o,
    output logic        reg_data_valid_o,
    output logic        branch_hit_o,
    output logic [31:0] branch_pc_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o
);

    typedef enum logic {StIdle, StShift} state_t;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpSll  = 4'd2;
    localparam logic [3:0] OpSlt  = 4'd3;
    localparam logic [3:0] OpSltu = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpOr   = 4'd8;
    localparam logic [3:0] OpAnd  = 4'd9;
    localparam logic [2:0] BrJalr = 3'd7;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [3:0]  sh_op_q, sh_op_d;
    logic [5:0]  sh_rd_q, sh_rd_d;

    logic [31:0] reg_data_q, reg_data_d;
    logic [5:0]  reg_id_q, reg_id_d;
    logic        reg_valid_q, reg_valid_d;
    logic        branch_hit_q, branch_hit_d;
    logic [31:0] branch_pc_q, branch_pc_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic        accept;
    logic        serial_op;
    logic        is_jalr;
    logic        taken;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  step_amt;
    logic [31:0] shift_step;

    assign busy_o    = (state_q == StShift);
    assign accept    = in_valid && !flush && !busy_o;
    assign is_jalr   = (br_op == BrJalr);
    assign serial_op = (BARREL_SHIFTER == 0) &&
                       ((alu_op == OpSll) || (alu_op == OpSrl) || (alu_op == OpSra));
    assign shamt     = reg_op2[4:0];
    assign addr      = reg_op1 + imm;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OpAdd:   alu_res = reg_op1 + reg_op2;
            OpSub:   alu_res = reg_op1 - reg_op2;
            OpSll:   alu_res = reg_op1 << shamt;
            OpSlt:   alu_res = {31'd0, $signed(reg_op1) < $signed(reg_op2)};
            OpSltu:  alu_res = {31'd0, reg_op1 < reg_op2};
            OpXor:   alu_res = reg_op1 ^ reg_op2;
            OpSrl:   alu_res = reg_op1 >> shamt;
            OpSra:   alu_res = $signed(reg_op1) >>> shamt;
            OpOr:    alu_res = reg_op1 | reg_op2;
            OpAnd:   alu_res = reg_op1 & reg_op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (br_op)
            3'd1:    taken = (reg_op1 == rs2_data);
            3'd2:    taken = (reg_op1 != rs2_data);
            3'd3:    taken = ($signed(reg_op1) < $signed(rs2_data));
            3'd4:    taken = !($signed(reg_op1) < $signed(rs2_data));
            3'd5:    taken = (reg_op1 < rs2_data);
            3'd6:    taken = !(reg_op1 < rs2_data);
            3'd7:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wdata = rs2_data;
        wstrb = 4'b1111;
        case (mem_size)
            2'd0: begin
                wdata = {4{rs2_data[7:0]}};
                wstrb = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                wdata = {2{rs2_data[15:0]}};
                wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                wdata = rs2_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Serial shifter moves 4 bits per cycle while at least 4 remain, then 1 bit per cycle.
    always_comb begin
        step_amt   = (cnt_q >= 5'd4) ? 3'd4 : 3'd1;
        shift_step = shreg_q;
        case (sh_op_q)
            OpSll:   shift_step = shreg_q << step_amt;
            OpSrl:   shift_step = shreg_q >> step_amt;
            default: shift_step = $signed(shreg_q) >>> step_amt;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sh_op_d      = sh_op_q;
        sh_rd_d      = sh_rd_q;
        reg_data_d   = reg_data_q;
        reg_id_d     = reg_id_q;
        reg_valid_d  = 1'b0;
        branch_hit_d = 1'b0;
        branch_pc_d  = branch_pc_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (accept && serial_op) begin
                    state_d = StShift;
                    shreg_d = reg_op1;
                    cnt_d   = shamt;
                    sh_op_d = alu_op;
                    sh_rd_d = rd;
                end else if (accept) begin
                    reg_data_d   = is_jalr ? (pc + 32'd4) : alu_res;
                    reg_id_d     = rd;
                    reg_valid_d  = ((alu_op <= OpAnd) || is_jalr) && !is_load && !is_store &&
                                   (rd != 6'd0);
                    branch_hit_d = taken;
                    branch_pc_d  = is_jalr ? (addr & ~32'd1) : (pc + imm);
                    mem_req_d    = is_load || is_store;
                    mem_we_d     = is_store;
                    mem_addr_d   = addr;
                    mem_wdata_d  = wdata;
                    mem_wstrb_d  = is_store ? wstrb : 4'b0000;
                end
            end
            StShift: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    state_d     = StIdle;
                    reg_data_d  = shreg_q;
                    reg_id_d    = sh_rd_q;
                    reg_valid_d = (sh_rd_q != 6'd0);
                end else begin
                    shreg_d = shift_step;
                    cnt_d   = cnt_q - {2'd0, step_amt};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sh_op_q      <= '0;
            sh_rd_q      <= '0;
            reg_data_q   <= '0;
            reg_id_q     <= '0;
            reg_valid_q  <= 1'b0;
            branch_hit_q <= 1'b0;
            branch_pc_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sh_op_q      <= sh_op_d;
            sh_rd_q      <= sh_rd_d;
            reg_data_q   <= reg_data_d;
            reg_id_q     <= reg_id_d;
            reg_valid_q  <= reg_valid_d;
            branch_hit_q <= branch_hit_d;
            branch_pc_q  <= branch_pc_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign reg_data_o       = reg_data_q;
    assign reg_id_o         = reg_id_q;
    assign reg_data_valid_o = reg_valid_q;
    assign branch_hit_o     = branch_hit_q;
    assign branch_pc_o      = branch_pc_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_wstrb_o      = mem_wstrb_q;

endmodule

// File: tb/tb_execute_alu.sv
// Directed bench for execute_alu: a barrel-shifter instance and a serial-shifter instance
// share one input stimulus.
module tb_execute_alu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [2:0]  br_op = '0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  mem_size = '0;
    logic [31:0] reg_op1 = '0, reg_op2 = '0, rs2_data = '0, imm = '0, pc = '0;
    logic [5:0]  rd = '0;

    logic        b_busy, b_valid, b_hit, b_req, b_we;
    logic [31:0] b_data, b_bpc, b_addr, b_wdata;
    logic [5:0]  b_id;
    logic [3:0]  b_wstrb;
    logic        s_busy, s_valid, s_hit, s_req, s_we;
    logic [31:0] s_data, s_bpc, s_addr, s_wdata;
    logic [5:0]  s_id;
    logic [3:0]  s_wstrb;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    execute_alu #(.BARREL_SHIFTER(1)) u_barrel (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .br_op(br_op), .is_load(is_load), .is_store(is_store), .mem_size(mem_size),
        .reg_op1(reg_op1), .reg_op2(reg_op2), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .rd(rd), .busy_o(b_busy), .reg_data_o(b_data), .reg_id_o(b_id),
        .reg_data_valid_o(b_valid), .branch_hit_o(b_hit), .branch_pc_o(b_bpc),
        .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
        .mem_wstrb_o(b_wstrb)
    );

    execute_alu #(.BARREL_SHIFTER(0)) u_serial (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .br_op(br_op), .is_load(is_load), .is_store(is_store), .mem_size(mem_size),
        .reg_op1(reg_op1), .reg_op2(reg_op2), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .rd(rd), .busy_o(s_busy), .reg_data_o(s_data), .reg_id_o(s_id),
        .reg_data_valid_o(s_valid), .branch_hit_o(s_hit), .branch_pc_o(s_bpc),
        .mem_req_o(s_req), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .mem_wstrb_o(s_wstrb)
    );

    task automatic drive(input logic [3:0] op, input logic [2:0] br, input logic ld,
                         input logic st, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p, input logic [5:0] d);
        alu_op = op; br_op = br; is_load = ld; is_store = st; mem_size = sz;
        reg_op1 = a; reg_op2 = b; rs2_data = r2; imm = im; pc = p; rd = d;
        in_valid = 1'b1;
    endtask

    // Advance past one rising edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (b_data !== 32'd0 || b_id !== 6'd0 || b_valid !== 1'b0) begin
            $display("FAIL reset_wb: got %h/%h/%b expected 0/0/0", b_data, b_id, b_valid);
            tests_failed++;
        end
        tests_run++;
        if (b_hit !== 1'b0 || b_bpc !== 32'd0 || b_req !== 1'b0 || b_we !== 1'b0) begin
            $display("FAIL reset_br_mem: got %b/%h/%b/%b expected 0", b_hit, b_bpc, b_req, b_we);
            tests_failed++;
        end
        tests_run++;
        if (b_addr !== 32'd0 || b_wdata !== 32'd0 || b_wstrb !== 4'd0 || s_busy !== 1'b0) begin
            $display("FAIL reset_misc: got %h/%h/%b/%b expected 0", b_addr, b_wdata, b_wstrb,
                     s_busy);
            tests_failed++;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        drive(4'd0, 3'd0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd5);
        step();
        tests_run++;
        if (b_data !== 32'd0 || b_id !== 6'd5 || b_valid !== 1'b1) begin
            $display("FAIL add_wrap: got %h/%0d/%b expected 0/5/1", b_data, b_id, b_valid);
            tests_failed++;
        end
        step();
        tests_run++;
        if (b_valid !== 1'b0 || b_data !== 32'd0) begin
            $display("FAIL add_pulse: got valid %b data %h expected 0/0", b_valid, b_data);
            tests_failed++;
        end
        drive(4'd0, 3'd0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd0);
        step();
        tests_run++;
        if (b_valid !== 1'b0 || b_id !== 6'd0) begin
            $display("FAIL add_rd0: got valid %b id %0d expected 0/0", b_valid, b_id);
            tests_failed++;
        end
        drive(4'd1, 3'd0, 1'b0, 1'b0, 2'd2, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 6'd9);
        step();
        tests_run++;
        if (b_data !== 32'hFFFF_FFFE || b_valid !== 1'b1) begin
            $display("FAIL sub: got %h/%b expected fffffffe/1", b_data, b_valid);
            tests_failed++;
        end
    endtask

    task automatic test_compare();
        drive(4'd3, 3'd0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd3);
        step();
        tests_run++;
        if (b_data !== 32'd1) begin
            $display("FAIL slt: got %h expected 00000001", b_data);
            tests_failed++;
        end
        drive(4'd4, 3'd0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd3);
        step();
        tests_run++;
        if (b_data !== 32'd0 || b_valid !== 1'b1) begin
            $display("FAIL sltu: got %h/%b expected 0/1", b_data, b_valid);
            tests_failed++;
        end
        drive(4'd5, 3'd0, 1'b0, 1'b0, 2'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0, 32'd0,
              6'd4);
        step();
        tests_run++;
        if (b_data !== 32'hFF00_EDCB) begin
            $display("FAIL xor: got %h expected ff00edcb", b_data);
            tests_failed++;
        end
    endtask

    task automatic test_branch();
        drive(4'd15, 3'd3, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFF8,
              32'h100, 6'd0);
        step();
        tests_run++;
        if (b_hit !== 1'b1 || b_bpc !== 32'h0000_00F8 || b_valid !== 1'b0) begin
            $display("FAIL blt: got hit %b pc %h valid %b expected 1/000000f8/0", b_hit, b_bpc,
                     b_valid);
            tests_failed++;
        end
        drive(4'd15, 3'd4, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFF8,
              32'h100, 6'd0);
        step();
        tests_run++;
        if (b_hit !== 1'b0) begin
            $display("FAIL bge_not_taken: got hit %b expected 0", b_hit);
            tests_failed++;
        end
        drive(4'd15, 3'd7, 1'b0, 1'b0, 2'd2, 32'h2001, 32'd0, 32'd0, 32'd2, 32'h100, 6'd1);
        step();
        tests_run++;
        if (b_hit !== 1'b1 || b_bpc !== 32'h2002 || b_data !== 32'h104 || b_valid !== 1'b1) begin
            $display("FAIL jalr: got %b/%h/%h/%b expected 1/00002002/00000104/1", b_hit, b_bpc,
                     b_data, b_valid);
            tests_failed++;
        end
        step();
        tests_run++;
        if (b_hit !== 1'b0 || b_bpc !== 32'h2002) begin
            $display("FAIL branch_pulse: got hit %b pc %h expected 0/00002002", b_hit, b_bpc);
            tests_failed++;
        end
    endtask

    task automatic test_memory();
        drive(4'd15, 3'd0, 1'b0, 1'b1, 2'd0, 32'h1000, 32'd0, 32'hAB, 32'd3, 32'd0, 6'd0);
        step();
        tests_run++;
        if (b_req !== 1'b1 || b_we !== 1'b1 || b_addr !== 32'h1003 || b_wstrb !== 4'b1000 ||
            b_wdata !== 32'hABAB_ABAB) begin
            $display("FAIL store_byte: got %b/%b/%h/%b/%h expected 1/1/00001003/1000/abababab",
                     b_req, b_we, b_addr, b_wstrb, b_wdata);
            tests_failed++;
        end
        drive(4'd15, 3'd0, 1'b0, 1'b1, 2'd1, 32'h1000, 32'd0, 32'h5678_1234, 32'd2, 32'd0,
              6'd0);
        step();
        tests_run++;
        if (b_wstrb !== 4'b1100 || b_wdata !== 32'h1234_1234 || b_addr !== 32'h1002) begin
            $display("FAIL store_half: got %b/%h/%h expected 1100/12341234/00001002", b_wstrb,
                     b_wdata, b_addr);
            tests_failed++;
        end
        drive(4'd0, 3'd0, 1'b1, 1'b0, 2'd2, 32'h2000, 32'd0, 32'd0, 32'h10, 32'd0, 6'd3);
        step();
        tests_run++;
        if (b_req !== 1'b1 || b_we !== 1'b0 || b_wstrb !== 4'd0 || b_valid !== 1'b0 ||
            b_addr !== 32'h2010) begin
            $display("FAIL load: got %b/%b/%b/%b/%h expected 1/0/0000/0/00002010", b_req, b_we,
                     b_wstrb, b_valid, b_addr);
            tests_failed++;
        end
        step();
        tests_run++;
        if (b_req !== 1'b0) begin
            $display("FAIL mem_pulse: got req %b expected 0", b_req);
            tests_failed++;
        end
    endtask

    task automatic test_flush_input();
        drive(4'd8, 3'd0, 1'b0, 1'b0, 2'd2, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0, 6'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (b_valid !== 1'b0 || b_id !== 6'd3 || s_busy !== 1'b0) begin
            $display("FAIL flush_input: got valid %b id %0d busy %b expected 0/3/0", b_valid,
                     b_id, s_busy);
            tests_failed++;
        end
    endtask

    task automatic test_barrel_shift();
        int guard;
        drive(4'd7, 3'd0, 1'b0, 1'b0, 2'd2, 32'h8000_0000, 32'd7, 32'd0, 32'd0, 32'd0, 6'd2);
        step();
        tests_run++;
        if (b_data !== 32'hFF00_0000 || b_valid !== 1'b1 || b_busy !== 1'b0) begin
            $display("FAIL barrel_sra: got %h/%b/%b expected ff000000/1/0", b_data, b_valid,
                     b_busy);
            tests_failed++;
        end
        guard = 0;
        while (s_busy === 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        step();
    endtask

    task automatic test_serial_shift(input string name, input logic [3:0] op,
                                     input logic [31:0] a, input logic [4:0] n,
                                     input logic [31:0] expected, input int exp_busy);
        int cycles;
        drive(op, 3'd0, 1'b0, 1'b0, 2'd2, a, {27'd0, n}, 32'd0, 32'd0, 32'd0, 6'd12);
        step();
        cycles = 0;
        while (s_busy === 1'b1 && cycles < 40) begin
            tests_run++;
            if (s_valid !== 1'b0) begin
                $display("FAIL %s_early_valid: got %b expected 0", name, s_valid);
                tests_failed++;
            end
            cycles++;
            step();
        end
        tests_run++;
        if (cycles != exp_busy || s_data !== expected || s_valid !== 1'b1 || s_id !== 6'd12) begin
            $display("FAIL %s: got busy %0d data %h valid %b id %0d expected %0d/%h/1/12", name,
                     cycles, s_data, s_valid, s_id, exp_busy, expected);
            tests_failed++;
        end
        step();
        tests_run++;
        if (s_valid !== 1'b0) begin
            $display("FAIL %s_pulse: got valid %b expected 0", name, s_valid);
            tests_failed++;
        end
    endtask

    task automatic test_serial_flush();
        drive(4'd2, 3'd0, 1'b0, 1'b0, 2'd2, 32'd1, 32'd31, 32'd0, 32'd0, 32'd0, 6'd7);
        step();
        step();
        step();
        tests_run++;
        if (s_busy !== 1'b1) begin
            $display("FAIL flush_busy_c3: got busy %b expected 1", s_busy);
            tests_failed++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
            $display("FAIL shift_flush: got busy %b valid %b expected 0/0", s_busy, s_valid);
            tests_failed++;
        end
        step();
        tests_run++;
        if (s_valid !== 1'b0) begin
            $display("FAIL shift_flush_late: got valid %b expected 0", s_valid);
            tests_failed++;
        end
        drive(4'd0, 3'd0, 1'b0, 1'b0, 2'd2, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 6'd4);
        step();
        tests_run++;
        if (s_data !== 32'd5 || s_valid !== 1'b1 || s_id !== 6'd4) begin
            $display("FAIL add_after_flush: got %h/%b/%0d expected 5/1/4", s_data, s_valid, s_id);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_shift();
        drive(4'd2, 3'd0, 1'b0, 1'b0, 2'd2, 32'd1, 32'd31, 32'd0, 32'd0, 32'd0, 6'd8);
        step();
        step();
        resetn = 1'b0;
        #1;
        tests_run++;
        if (s_busy !== 1'b0 || s_data !== 32'd0 || s_id !== 6'd0 || s_valid !== 1'b0) begin
            $display("FAIL reset_mid_shift: got %b/%h/%0d/%b expected 0/0/0/0", s_busy, s_data,
                     s_id, s_valid);
            tests_failed++;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_compare();
        test_branch();
        test_memory();
        test_flush_input();
        test_barrel_shift();
        test_serial_shift("serial_sra7", 4'd7, 32'h8000_0000, 5'd7, 32'hFF00_0000, 5);
        test_serial_shift("serial_sll0", 4'd2, 32'h0000_0001, 5'd0, 32'h0000_0001, 1);
        test_serial_shift("serial_srl4", 4'd6, 32'h0000_00F0, 5'd4, 32'h0000_000F, 2);
        test_serial_shift("serial_srl5", 4'd6, 32'h0000_0080, 5'd5, 32'h0000_0004, 3);
        test_serial_shift("serial_sll30", 4'd2, 32'h0000_0003, 5'd30, 32'hC000_0000, 10);
        test_serial_flush();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
